// File: rtl/seg7_pkg.sv
// Shared constants, glyphs, state encoding and snapshot layout for the 6-digit time display.
package seg7_pkg;

    localparam int unsigned DIGITS  = 6;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned BCD_W   = 8;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp is off in all of them.
    localparam logic [SEG_W-1:0] SEG_0    = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1    = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2    = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3    = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4    = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5    = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6    = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7    = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8    = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9    = 8'h90;
    localparam logic [SEG_W-1:0] SEG_DASH = 8'hBF;
    localparam logic [SEG_W-1:0] SEG_OFF  = 8'hFF;

    localparam logic [DIGITS-1:0] AN_OFF = 6'h3F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [BCD_W-1:0] hour;
        logic [BCD_W-1:0] minute;
        logic [BCD_W-1:0] second;
    } time_bcd_t;

    // Digit 0 is seconds units, digit 5 is hours tens.
    function automatic logic [NIB_W-1:0] digit_nibble(input time_bcd_t t,
                                                      input logic [IDX_W-1:0] idx);
        logic [NIB_W-1:0] nib;
        nib = 4'hF;
        case (idx)
            3'd0:    nib = t.second[3:0];
            3'd1:    nib = t.second[7:4];
            3'd2:    nib = t.minute[3:0];
            3'd3:    nib = t.minute[7:4];
            3'd4:    nib = t.hour[3:0];
            3'd5:    nib = t.hour[7:4];
            default: nib = 4'hF;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment glyph {g..a}; non-decimal codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0]   bcd,
    output logic [GLYPH_W-1:0] glyph_c
);

    always_comb begin
        glyph_c = SEG_DASH[GLYPH_W-1:0];
        case (bcd)
            4'd0:    glyph_c = SEG_0[GLYPH_W-1:0];
            4'd1:    glyph_c = SEG_1[GLYPH_W-1:0];
            4'd2:    glyph_c = SEG_2[GLYPH_W-1:0];
            4'd3:    glyph_c = SEG_3[GLYPH_W-1:0];
            4'd4:    glyph_c = SEG_4[GLYPH_W-1:0];
            4'd5:    glyph_c = SEG_5[GLYPH_W-1:0];
            4'd6:    glyph_c = SEG_6[GLYPH_W-1:0];
            4'd7:    glyph_c = SEG_7[GLYPH_W-1:0];
            4'd8:    glyph_c = SEG_8[GLYPH_W-1:0];
            4'd9:    glyph_c = SEG_9[GLYPH_W-1:0];
            default: glyph_c = SEG_DASH[GLYPH_W-1:0];
        endcase
    end

endmodule

// File: rtl/seg7_time_scan_driver.sv
// Tear-free hh:mm:ss scan driver for a 6-digit common-anode display with inter-digit blanking.
// Optional ring blink is built only when SEG_BLINK_EN is defined.
module seg7_time_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 5_000_000,
    parameter int unsigned DIGIT_HZ     = 5_000,
    parameter int unsigned BLANK_CYCLES = 50,
    parameter int unsigned BLINK_HZ     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BCD_W-1:0]  hour_bcd_in,
    input  logic [BCD_W-1:0]  minute_bcd_in,
    input  logic [BCD_W-1:0]  second_bcd_in,
    input  logic              ring,
    input  logic              counting,
    output logic [DIGITS-1:0] an_n,
    output logic [SEG_W-1:0]  seg_n
);

    localparam int unsigned DWELL = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    // The blank gap must be non-empty and leave some drive time in every dwell.
    if (BLANK_CYCLES == 0 || BLANK_CYCLES >= DWELL || BLINK_HZ == 0) begin : g_bad_cfg
        $error("seg7_time_scan_driver: invalid BLANK_CYCLES/DIGIT_HZ/BLINK_HZ combination");
    end

    logic [CNT_W-1:0]   dwell_cnt;
    logic [IDX_W-1:0]   digit_idx;
    time_bcd_t          snap_q;
    scan_state_e        state_q;
    scan_state_e        state_d;
    logic               dwell_wrap_c;
    logic               frame_wrap_c;
    logic [NIB_W-1:0]   nibble_c;
    logic [GLYPH_W-1:0] glyph_c;
    logic               dp_on_c;
    logic               blank_mask_c;
    logic [DIGITS-1:0]  an_d;
    logic [SEG_W-1:0]   seg_d;

    assign dwell_wrap_c = (dwell_cnt == DWELL_LAST);
    assign frame_wrap_c = dwell_wrap_c && (digit_idx == IDX_LAST);

    // Dwell counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            digit_idx <= '0;
        end else if (dwell_wrap_c) begin
            dwell_cnt <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

    // Frame snapshot: taken only as the index wraps 5->0 so a frame never mixes two times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (frame_wrap_c) begin
            snap_q <= '{hour: hour_bcd_in, minute: minute_bcd_in, second: second_bcd_in};
        end
    end

    // Blank/drive FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Blank/drive FSM: next state, aligned so BLANK covers dwell counts 0..BLANK_CYCLES-1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (dwell_cnt == BLANK_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (dwell_wrap_c)            state_d = ST_BLANK;
            default:                               state_d = ST_BLANK;
        endcase
    end

    assign nibble_c = digit_nibble(snap_q, digit_idx);

    bcd_to_seg7 u_decode (
        .bcd     (nibble_c),
        .glyph_c (glyph_c)
    );

    // Separator dots between hh.mm and mm.ss follow counting live.
    assign dp_on_c = counting && ((digit_idx == IDX_W'(2)) || (digit_idx == IDX_W'(4)));

`ifdef SEG_BLINK_EN
    localparam int unsigned HALF    = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BLINK_W-1:0] HALF_LAST = BLINK_W'(HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               hidden_q;

    // Holding the counter at zero while ring is low makes every rising edge start visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            hidden_q  <= 1'b0;
        end else if (!ring) begin
            blink_cnt <= '0;
            hidden_q  <= 1'b0;
        end else if (blink_cnt == HALF_LAST) begin
            blink_cnt <= '0;
            hidden_q  <= ~hidden_q;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Gating with live ring lets the display go steady on the same edge ring drops.
    assign blank_mask_c = ring & hidden_q;
`else
    logic unused_ring;
    assign unused_ring  = ring;
    assign blank_mask_c = 1'b0;
`endif

    // Output decode: next values for the registered anode/segment drivers.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_q == ST_DRIVE) begin
            an_d  = ~(DIGITS'(1) << digit_idx);
            seg_d = {~dp_on_c, glyph_c};
        end
        if (blank_mask_c) begin
            an_d = AN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= AN_OFF;
            seg_n <= SEG_OFF;
        end else begin
            an_n  <= an_d;
            seg_n <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_time_scan_driver.sv
// Randomized bench for seg7_time_scan_driver against a cycle-count reference model.
// Blink behaviour is modelled when SEG_BLINK_EN is defined; blink rate is sped up here.
`timescale 1ns/1ps
module tb_seg7_time_scan_driver;

    localparam int unsigned CLK_HZ   = 5_000_000;
    localparam int unsigned DIG_HZ   = 5_000;
    localparam int unsigned BLANK    = 50;
    localparam int unsigned BLINK    = 500;
    localparam int unsigned DWELL    = CLK_HZ / DIG_HZ;
    localparam int unsigned FRAME    = 6 * DWELL;
    localparam int unsigned HALF     = CLK_HZ / (2 * BLINK);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] hour_bcd;
    logic [7:0] minute_bcd;
    logic [7:0] second_bcd;
    logic       ring;
    logic       counting;
    logic [5:0] an_n;
    logic [7:0] seg_n;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned ring_run = 0;
    logic [23:0] snap_m   = 24'h0;

    logic [6:0] hi_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_time_scan_driver #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .DIGIT_HZ     (DIG_HZ),
        .BLANK_CYCLES (BLANK),
        .BLINK_HZ     (BLINK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hour_bcd_in   (hour_bcd),
        .minute_bcd_in (minute_bcd),
        .second_bcd_in (second_bcd),
        .ring          (ring),
        .counting      (counting),
        .an_n          (an_n),
        .seg_n         (seg_n)
    );

    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Active-high gfedcba shapes, inverted; dash for anything non-decimal.
    function automatic logic [7:0] glyph_m(input logic [3:0] v, input logic dp);
        logic [6:0] hi;
        hi = (v <= 4'd9) ? hi_tab[v] : 7'h40;
        return {~dp, ~hi};
    endfunction

    // One clock: predict from cycles since release, then sample just after the edge.
    task automatic step();
        int unsigned dig;
        int unsigned off;
        logic [3:0]  nib;
        logic [5:0]  e_an;
        logic [7:0]  e_seg;
        logic        dp;
        @(posedge clk);
        dig = (cyc / DWELL) % 6;
        off = cyc % DWELL;
        if (off < BLANK) begin
            e_an  = 6'h3F;
            e_seg = 8'hFF;
        end else begin
            e_an  = 6'h3F & ~(6'b000001 << dig);
            nib   = 4'((snap_m >> (4 * dig)) & 24'hF);
            dp    = counting && (dig == 2 || dig == 4);
            e_seg = glyph_m(nib, dp);
        end
`ifdef SEG_BLINK_EN
        if (ring && (((ring_run / HALF) % 2) == 1)) e_an = 6'h3F;
`endif
        if (cyc % FRAME == FRAME - 1) snap_m = {hour_bcd, minute_bcd, second_bcd};
        ring_run = ring ? ring_run + 1 : 0;
        cyc++;
        #1;
        check("an_n", 32'(an_n), 32'(e_an));
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
    endtask

    task automatic run(input int unsigned n, input bit rnd);
        for (int unsigned i = 0; i < n; i++) begin
            if (rnd) begin
                if ($urandom_range(0, 499) == 0) counting = ~counting;
                if ($urandom_range(0, 699) == 0) {hour_bcd, minute_bcd, second_bcd} = 24'($urandom);
                if ($urandom_range(0, 2999) == 0) ring = ~ring;
            end
            step();
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        ring_run = 0;
        snap_m   = 24'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        hour_bcd   = 8'h12;
        minute_bcd = 8'h34;
        second_bcd = 8'h56;
        ring       = 1'b0;
        counting   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 32'(an_n), 32'h3F);
        check("reset_seg", 32'(seg_n), 32'hFF);
        rst_n = 1'b1;
        model_reset();

        // Zero frame, then 12:34:56; seconds change while digit 3 drives.
        run(FRAME + 3 * DWELL + 500, 1'b0);
        second_bcd = 8'h57;
        run(2 * FRAME - (FRAME + 3 * DWELL + 500), 1'b0);
        run(FRAME, 1'b0);

        // Invalid tens digit and separator dots.
        minute_bcd = 8'hA5;
        counting   = 1'b1;
        run(FRAME + 100, 1'b0);
        counting   = 1'b0;
        run(FRAME, 1'b0);

        // Random inputs, counting and occasional ring toggles.
        run(2 * FRAME, 1'b1);

        // Sustained ring across several blink half-periods, then drop it.
        ring = 1'b0;
        step();
        ring = 1'b1;
        run(3 * HALF + 100, 1'b0);
        ring = 1'b0;
        run(300, 1'b0);
        ring = 1'b1;
        run(HALF + 50, 1'b0);
        ring = 1'b0;
        run(100, 1'b0);

        // Async reset in the middle of digit 4's drive window.
        for (int unsigned i = 0; i < FRAME + DWELL; i++) begin
            if (((cyc % FRAME) / DWELL) == 4 && (cyc % DWELL) > BLANK + 10) break;
            step();
        end
        check("pre_reset_an", 32'(an_n), 32'h2F);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", 32'(an_n), 32'h3F);
        check("async_seg", 32'(seg_n), 32'hFF);
        @(posedge clk);
        #1;
        check("held_an", 32'(an_n), 32'h3F);
        rst_n = 1'b1;
        model_reset();
        run(FRAME + 2000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
